// File: rtl/obi_multi_port_bridge.sv
// N-requester OBI bridge: arbitrates masters onto one memory port and routes in-order responses back.
// Define OBI_BRIDGE_RR_ARB_EN for round-robin arbitration; default build uses fixed lowest-index priority.
module obi_multi_port_bridge #(
    parameter int N_M     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4,
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_M-1:0]        m_req,
    output logic [N_M-1:0]        m_gnt,
    input  logic [N_M*AW-1:0]     m_addr,
    input  logic [N_M-1:0]        m_we,
    input  logic [N_M*DW/8-1:0]   m_be,
    input  logic [N_M*DW-1:0]     m_wdata,
    output logic [N_M-1:0]        m_rvalid,
    output logic [DW-1:0]         m_rdata,
    output logic                  s_req,
    input  logic                  s_gnt,
    output logic [AW-1:0]         s_addr,
    output logic                  s_we,
    output logic [DW/8-1:0]       s_be,
    output logic [DW-1:0]         s_wdata,
    input  logic                  s_rvalid,
    input  logic [DW-1:0]         s_rdata,
    output logic [CW-1:0]         out_cnt,
    output logic                  proto_err
);

    localparam int IW    = (N_M > 1) ? $clog2(N_M) : 1;
    localparam int PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int DEPTH = 1 << PW;
    localparam int BW    = DW / 8;

    logic [IW-1:0] id_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          perr_q, perr_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_sel_q, lock_sel_d;
    logic [IW-1:0] arb_sel;
    logic [IW-1:0] sel;
    logic [IW-1:0] head;
    logic          full;
    logic          push;
    logic          pop;

`ifdef OBI_BRIDGE_RR_ARB_EN
    logic [IW-1:0] rr_q, rr_d;
    logic          arb_found;
    int            arb_idx;

    // Search begins at the master after the last one granted, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int k = 0; k < N_M; k++) begin
            arb_idx = int'(rr_q) + k;
            if (arb_idx >= N_M) arb_idx = arb_idx - N_M;
            if (!arb_found && m_req[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = IW'(arb_idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (push) rr_d = (sel == IW'(N_M - 1)) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_q <= '0;
        else      rr_q <= rr_d;
    end
`else
    always_comb begin
        arb_sel = '0;
        for (int k = N_M - 1; k >= 0; k--) begin
            if (m_req[k]) arb_sel = IW'(k);
        end
    end
`endif

    // A stalled address phase keeps its master until granted, whatever else requests.
    assign sel  = lock_q ? lock_sel_q : arb_sel;
    assign full = (cnt_q == CW'(MAX_OUT));

    assign s_req   = (|m_req) & ~full;
    assign s_addr  = s_req ? m_addr[int'(sel)*AW +: AW]   : '0;
    assign s_we    = s_req ? m_we[sel]                     : 1'b0;
    assign s_be    = s_req ? m_be[int'(sel)*BW +: BW]      : '0;
    assign s_wdata = s_req ? m_wdata[int'(sel)*DW +: DW]   : '0;

    assign push = s_req & s_gnt;
    assign pop  = s_rvalid & (cnt_q != '0);
    assign head = id_q[rd_ptr_q];

    always_comb begin
        m_gnt = '0;
        if (push) m_gnt[sel] = 1'b1;
    end

    always_comb begin
        m_rvalid = '0;
        if (pop) m_rvalid[head] = 1'b1;
    end

    assign m_rdata = pop ? s_rdata : '0;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        perr_d     = perr_q;
        lock_d     = s_req & ~s_gnt;
        lock_sel_d = sel;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // A response with nothing outstanding is dropped and flagged.
        if (s_rvalid && cnt_q == '0) perr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            perr_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            perr_q     <= perr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) id_q[wr_ptr_q] <= sel;
    end

    assign out_cnt   = cnt_q;
    assign proto_err = perr_q;

endmodule
